ct_ifu_predecd_array_ctrl: RTL
==============================

# ct_ifu_predecd_array_ctrl

Access controller for one IFU icache predecode SRAM bank (32-bit word per entry). It shares the single-ported array among three requesters: refill writes from the line-fill path, fetch reads from the IF stage, and a hardware invalidate sweep that zeroes every entry. It produces registered chip-enable, write-enable, clock-enable, index and write-data signals for the array wrapper, and returns fetch read data with a valid strobe.

## Interface
- INDEX_W, 10, entry-index width; array depth is 2^INDEX_W (10 for 32K icache)
- DATA_W, 32, predecode word width
- forever_cpuclk  in  1  clock
- cpurst  in  1  synchronous, active-high reset
- inv_req  in  1  one-cycle pulse to start the invalidate sweep
- inv_busy  out  1  sweep in progress
- inv_done  out  1  one-cycle pulse at sweep completion
- refill_vld  in  1  refill write request; held until granted
- refill_index  in  INDEX_W  refill entry index
- refill_din  in  DATA_W  refill write data
- refill_grant  out  1  refill accepted this cycle (combinational)
- fetch_vld  in  1  fetch read request; held until granted
- fetch_index  in  INDEX_W  fetch entry index
- fetch_grant  out  1  fetch accepted this cycle (combinational)
- fetch_dout_vld  out  1  fetch read data valid
- fetch_dout  out  DATA_W  fetch read data
- array_cen_b  out  1  array chip enable, active-low (registered)
- array_wen_b  out  1  array write enable, active-low (registered)
- array_clk_en  out  1  local clock-gate enable for the array (registered)
- array_index  out  INDEX_W  array address (registered)
- array_din  out  DATA_W  array write data (registered)
- array_dout  in  DATA_W  array read data, valid the cycle after a read access

## Operation
- States: IDLE, SWEEP.
- IDLE, inv_req=1: go to SWEEP. Sweep counter cleared to 0. No grants that cycle (inv_req beats refill and fetch).
- IDLE, no inv_req: refill has priority over fetch, except in fairness override. At most one grant per cycle.
- Fairness: 2-bit streak counter increments on each refill grant while fetch_vld=1. When the counter is 3 and both refill and fetch are requesting, the next arbitration grants fetch. The counter clears on any fetch grant or whenever fetch_vld=0.
- SWEEP: each cycle issues a write command with index = counter and din = 0, then increments the counter. refill_grant and fetch_grant are held at 0, and requests stay pending.
- After the command for index 2^INDEX_W-1 is issued, the state returns to IDLE. inv_req during SWEEP is ignored.
- The streak counter clears on entry to SWEEP.
- Command register, loaded on any grant or sweep step:
  - Write: cen_b=0, wen_b=0, clk_en=1.
  - Read: cen_b=0, wen_b=1, clk_en=1.
  - No command: cen_b=1, wen_b=1, clk_en=0. Index and din hold their last values.
- Read return: a 1-bit flag tracks a read in the command register. fetch_dout_vld follows that flag one cycle later. fetch_dout = array_dout (combinational pass-through).
- A read in flight when SWEEP starts completes normally.
- Reset values:
  - Outputs: array_cen_b=1, array_wen_b=1, array_clk_en=0, array_index=0, array_din=0, fetch_dout_vld=0, inv_busy=0, inv_done=0. Grants are 0.
  - Internal: state IDLE, counters 0.
- Reset mid-sweep aborts the sweep with no inv_done. Reset mid-read drops the read: fetch_dout_vld=0 in the cycle after reset.

## Timing
- Grant cycle N → array command visible at N+1 → for reads, array_dout valid and fetch_dout_vld=1 at N+2.
- Back-to-back grants give one array access per cycle and read data every cycle.
- inv_req sampled at cycle N: inv_busy=1 from N+1 through the last sweep command cycle N+2^INDEX_W.
  - Sweep writes reach the array on cycles N+2 through N+2^INDEX_W+1.
  - inv_done=1 for exactly cycle N+2^INDEX_W+1, the cycle the final write is driven. inv_busy=0 that same cycle.
  - Grants are possible again from cycle N+2^INDEX_W+1.
- The counter index wraps from 2^INDEX_W-1 to 0 only through the SWEEP→IDLE exit and never causes a second pass.

## Test plan
- Reset, then idle: all array outputs hold cen_b=1, wen_b=1, clk_en=0, index=0; fetch_dout_vld=0.
- fetch_vld with fetch_index=0x05A at cycle 3 → fetch_grant@3; cen_b=0, wen_b=1, index=0x05A @4. Model returns 0xDEADBEEF @5 → fetch_dout_vld=1, fetch_dout=0xDEADBEEF @5.
- refill_vld and fetch_vld held continuously → refill granted 4 cycles, fetch 1 cycle, repeating. Writes carry refill_din at refill_index one cycle after grant.
- inv_req pulse at cycle 10 with INDEX_W=4 → writes of 0 to indices 0..15 on cycles 12..27; inv_busy=1 on cycles 11..26; inv_done=1 only @27. A refill held throughout is granted @27.
- Read granted at cycle 10 with inv_req at cycle 11 → fetch_dout_vld=1 @12. The sweep proceeds with no lost or duplicated index.
- cpurst at sweep index 7 → next cycle all outputs are at reset values and inv_done never pulses. A new inv_req restarts the sweep from index 0.

Source files
------------

// File: rtl/ct_ifu_predecd_array_ctrl_if.sv
// rtl/ct_ifu_predecd_array_ctrl_if.sv - requester, sweep and array-side signals of the predecode array controller
interface ct_ifu_predecd_array_ctrl_if #(
  parameter int INDEX_W = 10,
  parameter int DATA_W  = 32
);
  logic               inv_req;
  logic               inv_busy;
  logic               inv_done;
  logic               refill_vld;
  logic [INDEX_W-1:0] refill_index;
  logic [DATA_W-1:0]  refill_din;
  logic               refill_grant;
  logic               fetch_vld;
  logic [INDEX_W-1:0] fetch_index;
  logic               fetch_grant;
  logic               fetch_dout_vld;
  logic [DATA_W-1:0]  fetch_dout;
  logic               array_cen_b;
  logic               array_wen_b;
  logic               array_clk_en;
  logic [INDEX_W-1:0] array_index;
  logic [DATA_W-1:0]  array_din;
  logic [DATA_W-1:0]  array_dout;

  modport slave (
    input  inv_req, refill_vld, refill_index, refill_din, fetch_vld, fetch_index, array_dout,
    output inv_busy, inv_done, refill_grant, fetch_grant, fetch_dout_vld, fetch_dout,
           array_cen_b, array_wen_b, array_clk_en, array_index, array_din
  );

  modport master (
    output inv_req, refill_vld, refill_index, refill_din, fetch_vld, fetch_index, array_dout,
    input  inv_busy, inv_done, refill_grant, fetch_grant, fetch_dout_vld, fetch_dout,
           array_cen_b, array_wen_b, array_clk_en, array_index, array_din
  );
endinterface

// File: rtl/ct_ifu_predecd_array_ctrl.sv
// rtl/ct_ifu_predecd_array_ctrl.sv - arbitrates refill/fetch/invalidate-sweep access to one predecode SRAM bank
module ct_ifu_predecd_array_ctrl #(
  parameter int INDEX_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst,
  ct_ifu_predecd_array_ctrl_if.slave   bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]         state;
  logic [INDEX_W-1:0] sweep_cnt;
  logic [1:0]         streak;
  logic               fair_ovr;
  logic               rd_q;
  logic               cen_b_q;
  logic               wen_b_q;
  logic               clk_en_q;
  logic [INDEX_W-1:0] index_q;
  logic [DATA_W-1:0]  din_q;
  logic               dout_vld_q;
  logic               done_q;

  logic arb_ok;
  logic fetch_first;
  logic refill_gnt;
  logic fetch_gnt;
  logic sweep_step;
  logic sweep_last;

  // fair_ovr is armed by the fourth back-to-back refill grant and lets fetch win once
  always_comb begin
    arb_ok      = (state == ST_IDLE) && !bus.inv_req;
    fetch_first = fair_ovr && bus.fetch_vld;
    refill_gnt  = arb_ok && bus.refill_vld && !fetch_first;
    fetch_gnt   = arb_ok && bus.fetch_vld && !refill_gnt;
    sweep_step  = (state == ST_SWEEP);
    sweep_last  = sweep_step && (sweep_cnt == {INDEX_W{1'b1}});
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= ST_IDLE;
      sweep_cnt  <= '0;
      streak     <= 2'd0;
      fair_ovr   <= 1'b0;
      rd_q       <= 1'b0;
      cen_b_q    <= 1'b1;
      wen_b_q    <= 1'b1;
      clk_en_q   <= 1'b0;
      index_q    <= '0;
      din_q      <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.inv_req) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
          end
        end
        default: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_last) state <= ST_IDLE;
        end
      endcase

      done_q <= sweep_last;

      if (!arb_ok || fetch_gnt || !bus.fetch_vld) streak <= 2'd0;
      else if (refill_gnt)                        streak <= streak + 2'd1;
      fair_ovr <= refill_gnt && bus.fetch_vld && (streak == 2'd3);

      // Index and din keep their last values on idle cycles to avoid toggling the array pins
      if (sweep_step) begin
        {cen_b_q, wen_b_q, clk_en_q} <= 3'b001;
        index_q <= sweep_cnt;
        din_q   <= '0;
        rd_q    <= 1'b0;
      end else if (refill_gnt) begin
        {cen_b_q, wen_b_q, clk_en_q} <= 3'b001;
        index_q <= bus.refill_index;
        din_q   <= bus.refill_din;
        rd_q    <= 1'b0;
      end else if (fetch_gnt) begin
        {cen_b_q, wen_b_q, clk_en_q} <= 3'b011;
        index_q <= bus.fetch_index;
        rd_q    <= 1'b1;
      end else begin
        {cen_b_q, wen_b_q, clk_en_q} <= 3'b110;
        rd_q    <= 1'b0;
      end

      dout_vld_q <= rd_q;
    end
  end

  assign bus.refill_grant   = refill_gnt;
  assign bus.fetch_grant    = fetch_gnt;
  assign bus.inv_busy       = (state == ST_SWEEP);
  assign bus.inv_done       = done_q;
  assign bus.array_cen_b    = cen_b_q;
  assign bus.array_wen_b    = wen_b_q;
  assign bus.array_clk_en   = clk_en_q;
  assign bus.array_index    = index_q;
  assign bus.array_din      = din_q;
  assign bus.fetch_dout_vld = dout_vld_q;
  assign bus.fetch_dout     = bus.array_dout;
endmodule
